// File: rtl/min_max_ctrl_if.sv
// Configuration request channel of min_max_ctrl.
// Signal names are seen from the controller side (slave modport).
//   cfg_valid_i : request valid            cfg_ready_o : controller can accept
//   cfg_com_i   : requested command        cfg_min_i   : requested lower bound
//   cfg_max_i   : requested upper bound    cfg_err_o   : one-cycle reject pulse
interface min_max_ctrl_if #(
    parameter int unsigned VALSIZE = 4
);
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [1:0]         cfg_com_i;
    logic [VALSIZE-1:0] cfg_min_i;
    logic [VALSIZE-1:0] cfg_max_i;
    logic               cfg_err_o;

    // Requester side
    modport master (
        output cfg_valid_i, cfg_com_i, cfg_min_i, cfg_max_i,
        input  cfg_ready_o, cfg_err_o
    );

    // Controller side
    modport slave (
        input  cfg_valid_i, cfg_com_i, cfg_min_i, cfg_max_i,
        output cfg_ready_o, cfg_err_o
    );
endinterface

// File: rtl/min_max_ctrl.sv
// Front-end controller for min_max_top: accepts checked display configurations,
// holds them on registered outputs, generates the osc blink signal and can sweep
// val_o back and forth inside [min_o, max_o].
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   cfg                : configuration channel (min_max_ctrl_if.slave)
//   sweep_en_i         : enables the value sweep
//   com_o/min_o/max_o  : held configuration
//   osc_o              : blink signal, half-period OSC_DIV cycles
//   val_o              : current value
// Build option: MIN_MAX_CTRL_SWAP_EN accepts min > max requests with bounds swapped.
module min_max_ctrl #(
    parameter int unsigned VALSIZE = 4,
    parameter int unsigned OSC_DIV = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    min_max_ctrl_if.slave      cfg,
    input  logic               sweep_en_i,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic               osc_o,
    output logic [VALSIZE-1:0] val_o
);
    localparam int unsigned CNT_W = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSC_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         com_q, com_d;
    logic [VALSIZE-1:0] min_q, min_d;
    logic [VALSIZE-1:0] max_q, max_d;
    logic [VALSIZE-1:0] val_q, val_d;
    logic               osc_q, osc_d;
    logic               err_q, err_d;
    logic               dir_up_q, dir_up_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               hs;
    logic               wrap;
    logic               rise;

    assign hs   = cfg.cfg_valid_i && (state_q == IDLE);
    assign wrap = (cnt_q == CNT_MAX);
    assign rise = wrap && !osc_q;

    // Next-state: FSM, divider, sweep, then configuration load (load overrides sweep)
    always_comb begin
        state_d  = state_q;
        com_d    = com_q;
        min_d    = min_q;
        max_d    = max_q;
        val_d    = val_q;
        osc_d    = osc_q;
        err_d    = 1'b0;
        dir_up_d = dir_up_q;
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);

        if (wrap) begin
            osc_d = ~osc_q;
        end

        case (state_q)
            IDLE:    if (hs) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Step only while strictly inside the bound, so val never wraps
        if (rise && sweep_en_i) begin
            if (dir_up_q) begin
                if (val_q < max_q) begin
                    val_d = val_q + VALSIZE'(1);
                    if (val_d == max_q) dir_up_d = 1'b0;
                end
            end else begin
                if (val_q > min_q) begin
                    val_d = val_q - VALSIZE'(1);
                    if (val_d == min_q) dir_up_d = 1'b1;
                end
            end
        end

        if (hs) begin
            if (cfg.cfg_min_i <= cfg.cfg_max_i) begin
                com_d    = cfg.cfg_com_i;
                min_d    = cfg.cfg_min_i;
                max_d    = cfg.cfg_max_i;
                val_d    = cfg.cfg_min_i;
                dir_up_d = 1'b1;
            end else begin
`ifdef MIN_MAX_CTRL_SWAP_EN
                com_d    = cfg.cfg_com_i;
                min_d    = cfg.cfg_max_i;
                max_d    = cfg.cfg_min_i;
                val_d    = cfg.cfg_max_i;
                dir_up_d = 1'b1;
`else
                err_d    = 1'b1;
`endif
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            com_q    <= '0;
            min_q    <= '0;
            max_q    <= '1;
            val_q    <= '0;
            osc_q    <= 1'b0;
            err_q    <= 1'b0;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            com_q    <= com_d;
            min_q    <= min_d;
            max_q    <= max_d;
            val_q    <= val_d;
            osc_q    <= osc_d;
            err_q    <= err_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cfg.cfg_ready_o = (state_q == IDLE);
    assign cfg.cfg_err_o   = err_q;
    assign com_o           = com_q;
    assign min_o           = min_q;
    assign max_o           = max_q;
    assign osc_o           = osc_q;
    assign val_o           = val_q;
endmodule

// File: tb/tb_min_max_ctrl.sv
// Bench for min_max_ctrl: directed configuration/sweep/reset scenarios, a
// behavioural reference model compared every cycle, plus literal expectations.
module tb_min_max_ctrl;
    localparam int unsigned VS  = 4;
    localparam int unsigned DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sweep_en = 1'b0;
    logic [1:0]    com;
    logic [VS-1:0] mn, mx, vl;
    logic          osc;

    always #5 clk = ~clk;

    min_max_ctrl_if #(.VALSIZE(VS)) cfg_if ();

    min_max_ctrl #(.VALSIZE(VS), .OSC_DIV(DIV)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cfg        (cfg_if.slave),
        .sweep_en_i (sweep_en),
        .com_o      (com),
        .min_o      (mn),
        .max_o      (mx),
        .osc_o      (osc),
        .val_o      (vl)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: osc from elapsed cycles, val as a triangle wave over
    // the number of sweep steps taken since the last load.
    bit m_ok = 1'b0;
    int m_cyc, m_com, m_min, m_max, m_k;
    bit m_busy, m_err;
    bit m_hs, m_rise;
    int m_cmin, m_cmax;

    function automatic int tri_pos(input int k, input int span);
        int p;
        if (span == 0) return 0;
        p = k % (2 * span);
        return (p <= span) ? p : 2 * span - p;
    endfunction

    task automatic m_load(input int c, input int lo, input int hi);
        m_com = c;
        m_min = lo;
        m_max = hi;
        m_k   = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1'b1; m_cyc = 0; m_com = 0; m_min = 0; m_max = 15;
            m_k = 0; m_busy = 1'b0; m_err = 1'b0;
        end else begin
            m_cyc++;
            m_rise = (m_cyc % (2 * DIV)) == DIV;
            m_hs   = cfg_if.cfg_valid_i && !m_busy;
            m_busy = m_hs;
            m_err  = 1'b0;
            if (m_rise && sweep_en) m_k++;
            if (m_hs) begin
                m_cmin = int'(cfg_if.cfg_min_i);
                m_cmax = int'(cfg_if.cfg_max_i);
                if (m_cmin <= m_cmax) m_load(int'(cfg_if.cfg_com_i), m_cmin, m_cmax);
`ifdef MIN_MAX_CTRL_SWAP_EN
                else m_load(int'(cfg_if.cfg_com_i), m_cmax, m_cmin);
`else
                else m_err = 1'b1;
`endif
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("mdl_com",   int'(com), m_com);
            chk("mdl_min",   int'(mn),  m_min);
            chk("mdl_max",   int'(mx),  m_max);
            chk("mdl_val",   int'(vl),  m_min + tri_pos(m_k, m_max - m_min));
            chk("mdl_osc",   int'(osc), (m_cyc / DIV) % 2);
            chk("mdl_ready", int'(cfg_if.cfg_ready_o), int'(!m_busy));
            chk("mdl_err",   int'(cfg_if.cfg_err_o),   int'(m_err));
        end
    end

    // Handshake presented for one edge; returns 1 time unit after that edge
    task automatic cfg_send(input int c, input int lo, input int hi);
        @(negedge clk);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_com_i   = 2'(c);
        cfg_if.cfg_min_i   = VS'(lo);
        cfg_if.cfg_max_i   = VS'(hi);
        @(posedge clk);
        #1;
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    task automatic wait_rise();
        logic prev;
        bit   ok;
        prev = osc;
        ok   = 1'b0;
        for (int i = 0; i < 3 * int'(DIV); i++) begin
            @(posedge clk);
            #1;
            if (osc && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = osc;
        end
        if (!ok) chk("osc_rise_timeout", 0, 1);
    endtask

    int exp_seq [5] = '{4, 5, 4, 3, 4};

    initial begin
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_com_i   = '0;
        cfg_if.cfg_min_i   = '0;
        cfg_if.cfg_max_i   = '0;

        // Reset defaults and free-running osc
        repeat (2) @(posedge clk);
        #1;
        chk("rst_max", int'(mx), 15);
        chk("rst_ready", int'(cfg_if.cfg_ready_o), 1);
        chk("rst_val", int'(vl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("osc_c7", int'(osc), 0);
        @(posedge clk);
        #1 chk("osc_c8", int'(osc), 1);
        repeat (8) @(posedge clk);
        #1 chk("osc_c16", int'(osc), 0);
        repeat (8) @(posedge clk);
        #1 chk("osc_c24", int'(osc), 1);
        chk("idle_com", int'(com), 0);
        chk("idle_min", int'(mn), 0);
        chk("idle_err", int'(cfg_if.cfg_err_o), 0);

        // Legal configuration
        cfg_send(2, 3, 12);
        chk("ld_com", int'(com), 2);
        chk("ld_min", int'(mn), 3);
        chk("ld_max", int'(mx), 12);
        chk("ld_val", int'(vl), 3);
        chk("ld_ready_low", int'(cfg_if.cfg_ready_o), 0);
        chk("ld_err", int'(cfg_if.cfg_err_o), 0);
        @(posedge clk);
        #1 chk("ld_ready_back", int'(cfg_if.cfg_ready_o), 1);

        // min > max request
        cfg_send(1, 9, 4);
`ifdef MIN_MAX_CTRL_SWAP_EN
        chk("swap_min", int'(mn), 4);
        chk("swap_max", int'(mx), 9);
        chk("swap_val", int'(vl), 4);
        chk("swap_err", int'(cfg_if.cfg_err_o), 0);
`else
        chk("rej_err", int'(cfg_if.cfg_err_o), 1);
        chk("rej_com", int'(com), 2);
        chk("rej_min", int'(mn), 3);
        chk("rej_max", int'(mx), 12);
        chk("rej_val", int'(vl), 3);
`endif
        @(posedge clk);
        #1 chk("err_one_cycle", int'(cfg_if.cfg_err_o), 0);

        // Sweep 3..5
        cfg_send(0, 3, 5);
        sweep_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rise();
            chk("sweep_val", int'(vl), exp_seq[i]);
        end

        // Degenerate range holds its value
        sweep_en = 1'b0;
        cfg_send(1, 7, 7);
        sweep_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_rise();
            chk("flat_val", int'(vl), 7);
        end

        // Load on the same edge as a sweep step
        wait_rise();
        repeat (2 * DIV - 1) @(posedge clk);
        cfg_send(3, 2, 10);
        chk("sim_osc_rose", int'(osc), 1);
        chk("sim_val", int'(vl), 2);
        chk("sim_min", int'(mn), 2);
        wait_rise();
        chk("sim_next_val", int'(vl), 3);

        // Reset asserted during LOAD
        cfg_send(0, 1, 6);
        rst_n = 1'b0;
        sweep_en = 1'b0;
        @(posedge clk);
        #1;
        chk("rl_ready", int'(cfg_if.cfg_ready_o), 1);
        chk("rl_com", int'(com), 0);
        chk("rl_min", int'(mn), 0);
        chk("rl_max", int'(mx), 15);
        chk("rl_val", int'(vl), 0);
        chk("rl_osc", int'(osc), 0);
        chk("rl_err", int'(cfg_if.cfg_err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
